array_multiplier_16bit: RTL and testbench
=========================================

ARRAY_MULTIPLIER_16BIT -- requirements
Module: array_multiplier_16bit

Interface
REQ-001 Parameters: none; operand width fixed at 16, product width fixed at 32 (constants from shared package).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  A/B valid this cycle; product captured on this edge.
REQ-005 A  input  16  multiplicand, unsigned.
REQ-006 B  input  16  multiplier, unsigned.
REQ-007 P  output  32  registered unsigned product A*B.
REQ-008 out_valid  output  1  P holds a newly captured product this cycle.

Function
REQ-009 P SHALL equal the full-precision unsigned product of A and B; no truncation, overflow or saturation (32 bits always sufficient).
REQ-010 Rising edge with rst_n=1 and in_valid=1: P SHALL load A*B; out_valid SHALL be 1 in the following cycle.
REQ-011 Rising edge with rst_n=1 and in_valid=0: P SHALL hold its previous value; out_valid SHALL become 0.
REQ-012 Latency SHALL be exactly 1 clock, input edge to P/out_valid; throughput one product per clock, back-to-back in_valid supported without stalls.
REQ-013 No ready/backpressure; every in_valid cycle is accepted.
REQ-014 Product path SHALL be combinational from A/B to the P register input, settling within one clock period; no internal pipeline stages.
REQ-015 Boundaries: either operand 0 -> P=0x00000000; operand 1 -> P equals the other operand zero-extended; 0xFFFF*0xFFFF -> 0xFFFE0001 (max).
REQ-016 X/undefined A/B while in_valid=0 SHALL NOT affect P.

Reset
REQ-017 Rising edge with rst_n=0: P SHALL become 0x00000000 and out_valid 0, regardless of in_valid, A, B.
REQ-018 Reset SHALL take priority over a simultaneous in_valid capture; a product in flight during reset is discarded.
REQ-019 First capture after reset release SHALL occur on the first edge with rst_n=1 and in_valid=1.

Structure
REQ-020 Shared package SHALL hold OPERAND_W=16 and PRODUCT_W=32 constants.
REQ-021 Multiplier SHALL be a true array multiplier: 16x16 AND-gate partial products, 15 rows of carry-save full/half-adder cells, final ripple-carry adder; behavioural '*' SHALL NOT be used in the datapath.
REQ-022 One sub-module: full_adder (a, b, cin -> sum, cout), instantiated via generate loops; half adders may be full_adder with cin=0.
REQ-023 Only P and out_valid are registered; everything else combinational.

Verification
REQ-024 Reset: rst_n=0 one edge with in_valid=1, A=0xFFFF, B=0xFFFF -> P=0x00000000, out_valid=0.
REQ-025 Directed products, one per cycle, in_valid=1: 0x0000*0x0000->0x00000000; 0x0001*0x0001->0x00000001; 0x0002*0x0003->0x00000006; 0x0010*0x0010->0x00000100; 0x1234*0x5678->0x06260060, each with out_valid=1 one cycle later.
REQ-026 Corners: 0xAAAA*0x5555->0x38E31C72; 0xFFFF*0xFFFF->0xFFFE0001; 0x8000*0x8000->0x40000000; 0xFFFF*0x8000->0x7FFF8000; 0x0FFF*0x0FFF->0x00FFE001; 0x7FFF*0x7FFF->0x3FFF0001; 0xFFFE*0xFFFF->0xFFFD0002.
REQ-027 Hold: capture 0x1234*0x5678, then in_valid=0 with A/B changed for 3 cycles -> P stays 0x06260060, out_valid=0.
REQ-028 Back-to-back and mid-stream reset: stream >=20 random operand pairs with in_valid=1 -> every P matches reference A*B one cycle later; drop rst_n for one edge mid-stream -> P=0, out_valid=0, stream resumes correctly.

Source files
------------

// File: rtl/array_multiplier_16bit_pkg.sv
// rtl/array_multiplier_16bit_pkg.sv - shared widths for the 16x16 array multiplier
package array_multiplier_16bit_pkg;

    localparam int OPERAND_W = 16;
    localparam int PRODUCT_W = 32;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell of the multiplier array
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/array_multiplier_16bit.sv
// rtl/array_multiplier_16bit.sv - carry-save array multiplier with registered product
module array_multiplier_16bit
    import array_multiplier_16bit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [OPERAND_W-1:0] A,
    input  logic [OPERAND_W-1:0] B,
    output logic [PRODUCT_W-1:0] P,
    output logic                 out_valid
);

    logic [OPERAND_W-1:0][OPERAND_W-1:0] pp;
    logic [PRODUCT_W-1:0]                prod;

    // Row i adds partial product i to the shifted sum and aligned carries of row i-1;
    // its bit-0 sum is final product bit i.
    for (genvar i = 0; i < OPERAND_W; i++) begin : g_row
        logic [OPERAND_W:0]   s;
        logic [OPERAND_W-1:0] c;

        assign pp[i] = A & {OPERAND_W{B[i]}};

        if (i == 0) begin : g_first
            assign s = {1'b0, pp[0]};
            assign c = '0;
        end else begin : g_cells
            assign s[OPERAND_W] = 1'b0;
            for (genvar j = 0; j < OPERAND_W; j++) begin : g_cell
                full_adder u_fa (
                    .a    (pp[i][j]),
                    .b    (g_row[i-1].s[j+1]),
                    .cin  (g_row[i-1].c[j]),
                    .sum  (s[j]),
                    .cout (c[j])
                );
            end
        end

        assign prod[i] = s[0];
    end

    // Final ripple-carry merge of the last row's sums and carries into the upper half.
    for (genvar j = 0; j < OPERAND_W; j++) begin : g_fin
        logic cin;
        logic co;

        if (j == 0) begin : g_cin0
            assign cin = 1'b0;
        end else begin : g_cinj
            assign cin = g_fin[j-1].co;
        end

        if (j < OPERAND_W - 1) begin : g_add
            full_adder u_fa (
                .a    (g_row[OPERAND_W-1].s[j+1]),
                .b    (g_row[OPERAND_W-1].c[j]),
                .cin  (cin),
                .sum  (prod[OPERAND_W+j]),
                .cout (co)
            );
        end else begin : g_top
            // The full product always fits in 32 bits, so the top carry-out is never needed.
            assign prod[OPERAND_W+j] = g_row[OPERAND_W-1].s[j+1] ^ g_row[OPERAND_W-1].c[j] ^ cin;
            assign co                = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            P         <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            P         <= prod;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_array_multiplier_16bit.sv
// tb/tb_array_multiplier_16bit.sv - directed self-checking bench for array_multiplier_16bit
module tb_array_multiplier_16bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] A;
    logic [15:0] B;
    logic [31:0] P;
    logic        out_valid;

    int checks = 0;
    int passed = 0;

    array_multiplier_16bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .P         (P),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check_p(input string tag, input logic [31:0] exp_p, input logic exp_v);
        checks++;
        assert (P === exp_p && out_valid === exp_v) passed++;
        else $error("FAIL %s: P=%h out_valid=%b expected P=%h out_valid=%b",
                    tag, P, out_valid, exp_p, exp_v);
    endtask

    task automatic mul_step(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] exp_p);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(negedge clk);
        check_p(tag, exp_p, 1'b1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] ref_p;

        rst_n    = 1'b0;
        in_valid = 1'b1;
        A        = 16'hFFFF;
        B        = 16'hFFFF;
        @(negedge clk);
        check_p("reset", 32'h0000_0000, 1'b0);

        rst_n = 1'b1;
        mul_step("0x0*0x0",       16'h0000, 16'h0000, 32'h0000_0000);
        mul_step("1*1",           16'h0001, 16'h0001, 32'h0000_0001);
        mul_step("2*3",           16'h0002, 16'h0003, 32'h0000_0006);
        mul_step("10*10",         16'h0010, 16'h0010, 32'h0000_0100);
        mul_step("1234*5678",     16'h1234, 16'h5678, 32'h0626_0060);
        mul_step("AAAA*5555",     16'hAAAA, 16'h5555, 32'h38E3_1C72);
        mul_step("FFFF*FFFF",     16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        mul_step("8000*8000",     16'h8000, 16'h8000, 32'h4000_0000);
        mul_step("FFFF*8000",     16'hFFFF, 16'h8000, 32'h7FFF_8000);
        mul_step("0FFF*0FFF",     16'h0FFF, 16'h0FFF, 32'h00FF_E001);
        mul_step("7FFF*7FFF",     16'h7FFF, 16'h7FFF, 32'h3FFF_0001);
        mul_step("FFFE*FFFF",     16'hFFFE, 16'hFFFF, 32'hFFFD_0002);
        mul_step("zero_a",        16'h0000, 16'hBEEF, 32'h0000_0000);
        mul_step("one_a",         16'h0001, 16'hBEEF, 32'h0000_BEEF);
        mul_step("one_b",         16'hCAFE, 16'h0001, 32'h0000_CAFE);

        mul_step("hold_load",     16'h1234, 16'h5678, 32'h0626_0060);
        in_valid = 1'b0;
        A = 16'hFFFF; B = 16'hFFFF;
        @(negedge clk);
        check_p("hold1", 32'h0626_0060, 1'b0);
        A = 16'h0000; B = 16'h0003;
        @(negedge clk);
        check_p("hold2", 32'h0626_0060, 1'b0);
        A = 'x; B = 'x;
        @(negedge clk);
        check_p("hold3_x", 32'h0626_0060, 1'b0);

        for (int k = 0; k < 24; k++) begin
            if (k == 12) begin
                rst_n    = 1'b0;
                in_valid = 1'b1;
                A        = 16'hFFFF;
                B        = 16'h7777;
                @(negedge clk);
                check_p("mid_reset", 32'h0000_0000, 1'b0);
                rst_n = 1'b1;
            end
            ra    = 16'($urandom);
            rb    = 16'($urandom);
            ref_p = {16'h0, ra} * {16'h0, rb};
            mul_step($sformatf("stream%0d", k), ra, rb, ref_p);
        end

        in_valid = 1'b0;
        @(negedge clk);
        check_p("idle_after_stream", ref_p, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
